// File: rtl/data_memory_port_pkg.sv
// Shared definitions for the data-side memory port.
//   dataPortState_ : transaction FSM states (IDLE, REQUEST, WAIT, HOLD)
//   BE_WORD        : byte-enable pattern used for every load (full word)
package pack;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        HOLD    = 2'd3
    } dataPortState_;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/data_memory_port.sv
// data_memory_port: bridges the Memory stage to the data-side bus.
// One transaction is in flight at a time. A load or store request from
// Memory is captured, presented on the bus until accepted, and its
// response is turned into either a held load result or a one-cycle store
// completion pulse. A watchdog synthesizes an error response when the bus
// stays silent for TIMEOUT_CYCLES cycles in WAIT (0 disables it).
//
// Bus request handshake: busRequestValid rises when a captured request is
// ready and stays high, with busWrite/busAddress/busWriteData/busByteEnable
// unchanged, until the cycle in which busRequestReady is also high; that
// cycle is the transfer. Responses are single-cycle busResponseValid
// strobes and are only looked at while waiting for one.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   loadRequest, storeValid      requests from Memory (store has priority)
//   address, storeData,
//   storeByteEnable              request payload from Memory
//   flush, advance               pipeline control from Memory/Writeback
//   loadData, loadDataValid,
//   loadFault                    held load result (until advance/flush)
//   storeComplete, storeFault    one-cycle store completion pulse
//   busRequest*, busWrite,
//   busAddress, busWriteData,
//   busByteEnable                bus request channel
//   busResponse*                 bus response channel
import pack::*;

module data_memory_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadRequest,
    input  logic        storeValid,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeByteEnable,
    input  logic        flush,
    input  logic        advance,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        loadFault,
    output logic        storeComplete,
    output logic        storeFault,
    output logic        busRequestValid,
    input  logic        busRequestReady,
    output logic        busWrite,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    output logic [3:0]  busByteEnable,
    input  logic        busResponseValid,
    input  logic [31:0] busResponseData,
    input  logic        busResponseError
);

    dataPortState_ state;
    dataPortState_ state_next;

    logic        kill;
    logic [31:0] timer;

    logic start_store;
    logic start_load;
    logic timed_out;
    logic response_seen;
    logic response_error;
    logic kill_now;

    // While storeComplete is high Memory has not yet dropped storeValid;
    // ignoring it for that cycle keeps the finished store from reissuing.
    assign start_store    = storeValid & ~storeComplete;
    assign start_load     = ~storeValid & loadRequest & ~flush;

    assign timed_out      = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES - 1);
    assign response_seen  = busResponseValid | timed_out;
    // A real response in the same cycle as the timeout wins.
    assign response_error = busResponseValid ? busResponseError : 1'b1;
    // A flush arriving with the response still kills a load.
    assign kill_now       = kill | (flush & ~busWrite);

    assign busRequestValid = (state == REQUEST);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_store || start_load) state_next = REQUEST;
            REQUEST: if (busRequestReady) state_next = WAIT;
            WAIT: begin
                if (response_seen) begin
                    if (busWrite || kill_now) state_next = IDLE;
                    else                      state_next = HOLD;
                end
            end
            HOLD:    if (advance || flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kill          <= 1'b0;
            timer         <= '0;
            loadData      <= '0;
            loadDataValid <= 1'b0;
            loadFault     <= 1'b0;
            storeComplete <= 1'b0;
            storeFault    <= 1'b0;
            busWrite      <= 1'b0;
            busAddress    <= '0;
            busWriteData  <= '0;
            busByteEnable <= '0;
        end else begin
            storeComplete <= 1'b0;
            storeFault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_store) begin
                        busWrite      <= 1'b1;
                        busAddress    <= address & ~32'h3;
                        busWriteData  <= storeData;
                        busByteEnable <= storeByteEnable;
                    end else if (start_load) begin
                        busWrite      <= 1'b0;
                        busAddress    <= address & ~32'h3;
                        busWriteData  <= '0;
                        busByteEnable <= BE_WORD;
                    end
                end
                REQUEST: begin
                    if (flush && !busWrite) kill <= 1'b1;
                    if (busRequestReady)    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 32'd1;
                    if (flush && !busWrite) kill <= 1'b1;
                    if (response_seen) begin
                        if (busWrite) begin
                            storeComplete <= 1'b1;
                            storeFault    <= response_error;
                        end else if (!kill_now) begin
                            loadData      <= response_error ? 32'h0 : busResponseData;
                            loadFault     <= response_error;
                            loadDataValid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (advance || flush) loadDataValid <= 1'b0;
                end
                default: ;
            endcase
            if (state_next == IDLE) kill <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_port.sv
module tb_data_memory_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        loadRequest, storeValid;
    logic [31:0] address, storeData;
    logic [3:0]  storeByteEnable;
    logic        flush, advance;
    logic [31:0] loadData;
    logic        loadDataValid, loadFault, storeComplete, storeFault;
    logic        busRequestValid, busRequestReady, busWrite;
    logic [31:0] busAddress, busWriteData;
    logic [3:0]  busByteEnable;
    logic        busResponseValid;
    logic [31:0] busResponseData;
    logic        busResponseError;

    int checks = 0;
    int failures = 0;

    // Scoreboard entries: {fault, data} expected for each completed transaction.
    logic [32:0] exp_q[$];

    data_memory_port #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .loadRequest(loadRequest), .storeValid(storeValid),
        .address(address), .storeData(storeData), .storeByteEnable(storeByteEnable),
        .flush(flush), .advance(advance),
        .loadData(loadData), .loadDataValid(loadDataValid), .loadFault(loadFault),
        .storeComplete(storeComplete), .storeFault(storeFault),
        .busRequestValid(busRequestValid), .busRequestReady(busRequestReady),
        .busWrite(busWrite), .busAddress(busAddress), .busWriteData(busWriteData),
        .busByteEnable(busByteEnable), .busResponseValid(busResponseValid),
        .busResponseData(busResponseData), .busResponseError(busResponseError)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        loadRequest = 0; storeValid = 0; address = 0; storeData = 0; storeByteEnable = 0;
        flush = 0; advance = 0; busRequestReady = 0; busResponseValid = 0;
        busResponseData = 0; busResponseError = 0;
    endtask

    task automatic wait_req(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (busRequestValid === 1'b1) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s request_timeout got=no_request exp=request", name); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++;
        if ({loadData, loadDataValid, loadFault, storeComplete, storeFault, busRequestValid,
             busWrite, busAddress, busWriteData, busByteEnable} !== '0) begin
            failures++; $display("FAIL reset_outputs got=nonzero exp=all_zero");
        end
    endtask

    task automatic test_load_basic();
        loadRequest = 1; address = 32'h0000_1006;
        tick();
        loadRequest = 0; address = 32'hFFFF_FFFF;
        checks++; if (busRequestValid !== 1) begin failures++; $display("FAIL load_req_valid got=%b exp=1", busRequestValid); end
        checks++; if (busAddress !== 32'h0000_1004) begin failures++; $display("FAIL load_addr got=%h exp=00001004", busAddress); end
        checks++; if (busWrite !== 0) begin failures++; $display("FAIL load_write got=%b exp=0", busWrite); end
        checks++; if (busByteEnable !== 4'hF) begin failures++; $display("FAIL load_be got=%h exp=f", busByteEnable); end
        busRequestReady = 1;
        tick();
        busRequestReady = 0;
        checks++; if (busRequestValid !== 0) begin failures++; $display("FAIL load_req_drop got=%b exp=0", busRequestValid); end
        busResponseValid = 1; busResponseData = 32'hA1B2_C3D4; busResponseError = 0;
        tick();
        busResponseValid = 0; busResponseData = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (loadDataValid !== 1 || loadData !== 32'hA1B2_C3D4 || loadFault !== 0) begin
                failures++; $display("FAIL load_hold cycle=%0d got=%b/%h/%b exp=1/a1b2c3d4/0", i, loadDataValid, loadData, loadFault);
            end
            tick();
        end
        advance = 1;
        tick();
        advance = 0;
        checks++; if (loadDataValid !== 0) begin failures++; $display("FAIL load_advance got=%b exp=0", loadDataValid); end
    endtask

    task automatic test_store_stall();
        int pulses;
        storeValid = 1; address = 32'h0000_2002; storeData = 32'h00EE_0000; storeByteEnable = 4'b0100;
        tick();
        address = 32'h1234_5678; storeData = 32'h5555_5555; storeByteEnable = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busRequestValid !== 1 || busWrite !== 1 || busAddress !== 32'h0000_2000 ||
                busWriteData !== 32'h00EE_0000 || busByteEnable !== 4'b0100) begin
                failures++;
                $display("FAIL store_stable cycle=%0d got=%b/%b/%h/%h/%h exp=1/1/00002000/00ee0000/4",
                         i, busRequestValid, busWrite, busAddress, busWriteData, busByteEnable);
            end
            if (i == 3) busRequestReady = 1;
            tick();
        end
        busRequestReady = 0;
        busResponseValid = 1; busResponseError = 0;
        tick();
        busResponseValid = 0;
        storeValid = 0;
        pulses = 0;
        checks++; if (storeComplete !== 1 || storeFault !== 0) begin failures++; $display("FAIL store_complete got=%b/%b exp=1/0", storeComplete, storeFault); end
        for (int i = 0; i < 4; i++) begin
            if (storeComplete === 1) pulses++;
            tick();
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL store_pulse_count got=%0d exp=1", pulses); end
        checks++; if (busRequestValid !== 0) begin failures++; $display("FAIL store_no_reissue got=%b exp=0", busRequestValid); end
    endtask

    task automatic test_flush_wait();
        loadRequest = 1; address = 32'h0000_3000;
        tick();
        loadRequest = 0; busRequestReady = 1;
        tick();
        busRequestReady = 0; flush = 1;
        tick();
        flush = 0; busResponseValid = 1; busResponseData = 32'hDEAD_BEEF;
        tick();
        busResponseValid = 0;
        checks++; if (loadDataValid !== 0) begin failures++; $display("FAIL flush_discard got=%b exp=0", loadDataValid); end
        loadRequest = 1; address = 32'h0000_3008;
        tick();
        loadRequest = 0;
        checks++;
        if (busRequestValid !== 1 || busAddress !== 32'h0000_3008 || loadDataValid !== 0) begin
            failures++; $display("FAIL flush_next_accept got=%b/%h/%b exp=1/00003008/0", busRequestValid, busAddress, loadDataValid);
        end
        busRequestReady = 1;
        tick();
        busRequestReady = 0; busResponseValid = 1; busResponseData = 32'h0BAD_F00D;
        tick();
        busResponseValid = 0;
        checks++; if (loadDataValid !== 1 || loadData !== 32'h0BAD_F00D) begin failures++; $display("FAIL flush_next_data got=%b/%h exp=1/0badf00d", loadDataValid, loadData); end
        advance = 1;
        tick();
        advance = 0;
    endtask

    task automatic test_priority();
        storeValid = 1; loadRequest = 1; address = 32'h0000_4004; storeData = 32'h1111_2222; storeByteEnable = 4'hF;
        tick();
        loadRequest = 0;
        checks++; if (busRequestValid !== 1 || busWrite !== 1) begin failures++; $display("FAIL priority_store got=%b/%b exp=1/1", busRequestValid, busWrite); end
        busRequestReady = 1;
        tick();
        busRequestReady = 0; busResponseValid = 1; busResponseError = 1;
        tick();
        busResponseValid = 0; busResponseError = 0; storeValid = 0;
        checks++; if (storeComplete !== 1 || storeFault !== 1) begin failures++; $display("FAIL priority_store_err got=%b/%b exp=1/1", storeComplete, storeFault); end
        tick();
    endtask

    task automatic test_timeout();
        loadRequest = 1; address = 32'h0000_5000;
        tick();
        loadRequest = 0; busRequestReady = 1;
        tick();
        busRequestReady = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (loadDataValid !== 0) begin failures++; $display("FAIL timeout_early wait=%0d got=%b exp=0", i, loadDataValid); end
        end
        tick();
        checks++;
        if (loadDataValid !== 1 || loadFault !== 1 || loadData !== 32'h0) begin
            failures++; $display("FAIL timeout_result got=%b/%b/%h exp=1/1/00000000", loadDataValid, loadFault, loadData);
        end
        advance = 1;
        tick();
        advance = 0;
    endtask

    task automatic test_reset_mid();
        storeValid = 1; address = 32'h0000_6000; storeData = 32'hCAFE_0000; storeByteEnable = 4'b1100;
        tick();
        busRequestReady = 1;
        tick();
        busRequestReady = 0;
        tick();
        reset = 1;
        tick();
        reset = 0; storeValid = 0;
        checks++;
        if ({loadData, loadDataValid, loadFault, storeComplete, storeFault, busRequestValid,
             busWrite, busAddress, busWriteData, busByteEnable} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs got=nonzero exp=all_zero");
        end
        busResponseValid = 1;
        tick();
        busResponseValid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (storeComplete !== 0 || busRequestValid !== 0) begin failures++; $display("FAIL reset_mid_late_resp cycle=%0d got=%b/%b exp=0/0", i, storeComplete, busRequestValid); end
            tick();
        end
    endtask

    // One randomized transaction; the reference model is the transaction-level
    // rule set: the word address, payload and result (data or 0/fault on error
    // or timeout), with loads killed by a flush and stores never killed.
    task automatic do_txn(input bit is_store, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int rdly, input int d, input bit to,
                          input bit err, input bit fl, input logic [31:0] rdata);
        bit ok;
        bit killed;
        logic [32:0] exp;
        logic [32:0] got;
        killed = fl && !is_store;
        if (!killed) begin
            if (to)        exp_q.push_back({1'b1, 32'h0});
            else if (err)  exp_q.push_back({1'b1, 32'h0});
            else           exp_q.push_back({1'b0, is_store ? 32'h0 : rdata});
        end
        if (is_store) storeValid = 1; else loadRequest = 1;
        address = addr; storeData = wdata; storeByteEnable = be;
        tick();
        loadRequest = 0;
        address = $urandom; storeData = $urandom; storeByteEnable = 4'($urandom);
        wait_req("rnd", ok);
        if (!ok) begin storeValid = 0; return; end
        checks++;
        if (busWrite !== is_store || busAddress !== {addr[31:2], 2'b00} ||
            busByteEnable !== (is_store ? be : 4'hF) || (is_store && busWriteData !== wdata)) begin
            failures++; $display("FAIL rnd_request got=%b/%h/%h/%h exp=%b/%h/%h/%h", busWrite, busAddress,
                                 busByteEnable, busWriteData, is_store, {addr[31:2], 2'b00}, is_store ? be : 4'hF, wdata);
        end
        for (int i = 0; i < rdly; i++) begin
            tick();
            checks++; if (busRequestValid !== 1 || busAddress !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL rnd_req_hold got=%b/%h exp=1/%h", busRequestValid, busAddress, {addr[31:2], 2'b00}); end
        end
        busRequestReady = 1;
        tick();
        busRequestReady = 0;
        for (int i = 0; i < 4; i++) begin
            flush = fl && (i == 0);
            busResponseValid = !to && (i == d);
            busResponseData = rdata; busResponseError = err;
            tick();
            flush = 0; busResponseValid = 0; busResponseData = 0; busResponseError = 0;
            if (!to && i == d) break;
        end
        if (is_store) begin
            storeValid = 0;
            exp = exp_q.pop_front();
            checks++; if (storeComplete !== 1 || storeFault !== exp[32]) begin failures++; $display("FAIL rnd_store got=%b/%b exp=1/%b", storeComplete, storeFault, exp[32]); end
            tick();
            checks++; if (storeComplete !== 0) begin failures++; $display("FAIL rnd_store_pulse got=%b exp=0", storeComplete); end
        end else if (killed) begin
            checks++; if (loadDataValid !== 0) begin failures++; $display("FAIL rnd_kill got=%b exp=0", loadDataValid); end
            tick();
            checks++; if (loadDataValid !== 0 || busRequestValid !== 0) begin failures++; $display("FAIL rnd_kill_after got=%b/%b exp=0/0", loadDataValid, busRequestValid); end
        end else begin
            exp = exp_q.pop_front();
            for (int i = 0; i <= int'($urandom_range(0, 2)); i++) begin
                got = {loadFault, loadData};
                checks++; if (loadDataValid !== 1 || got !== exp) begin failures++; $display("FAIL rnd_load got=%b/%h exp=1/%h", loadDataValid, got, exp); end
                if (i < 2) tick();
            end
            if ($urandom_range(0, 1) == 1) advance = 1; else flush = 1;
            tick();
            advance = 0; flush = 0;
            checks++; if (loadDataValid !== 0) begin failures++; $display("FAIL rnd_release got=%b exp=0", loadDataValid); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_txn($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(1, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_queue_left got=%0d exp=0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_basic();
        test_store_stall();
        test_flush_wait();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_port.md
# data_memory_port

Bridges the Memory stage to the data-side bus: turns Memory's load request and registered store request into single-outstanding bus transactions, holds load results until the pipeline advances, and signals store completion. Sits directly downstream of the Memory stage (consumes `storeValid`, address, `storeData`, byte enables) and feeds back `loadData`, `loadDataValid`, `storeComplete`. One transaction in flight at a time; includes a response-timeout watchdog.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles in WAIT without a response before a synthesized error response; 0 disables the watchdog.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `loadRequest`  in  1  Memory holds a valid, aligned, unflushed, trap-free load.
- `storeValid`  in  1  registered store request from Memory; stays high until `storeComplete`.
- `address`  in  32  byte address from Memory.
- `storeData`  in  32  lane-shifted store data.
- `storeByteEnable`  in  4  lane-shifted byte enables.
- `flush`  in  1  Memory/Writeback flush.
- `advance`  in  1  Memory stage advances this cycle.
- `loadData`  out  32  raw bus word for the load.
- `loadDataValid`  out  1  `loadData` valid; held until `advance`.
- `loadFault`  out  1  load ended in error; qualified by `loadDataValid`.
- `storeComplete`  out  1  one-cycle pulse when the store response returns.
- `storeFault`  out  1  pulse with `storeComplete` on an error response.
- `busRequestValid`  out  1  request valid.
- `busRequestReady`  in  1  request accepted when both valid and ready are high.
- `busWrite`  out  1  1 = store, 0 = load.
- `busAddress`  out  32  `{address[31:2],2'b00}` as captured.
- `busWriteData`  out  32  captured `storeData`.
- `busByteEnable`  out  4  captured enables; `4'b1111` for loads.
- `busResponseValid`  in  1  response strobe.
- `busResponseData`  in  32  response word.
- `busResponseError`  in  1  response error.

## Operation
- States: IDLE, REQUEST, WAIT, HOLD.
- IDLE:
  - `storeValid` has priority over `loadRequest`.
  - On either request, capture address, data and enables, set `busWrite`, go to REQUEST.
  - A `loadRequest` with `flush` high is ignored.
- REQUEST:
  - `busRequestValid` is high.
  - All bus request outputs stay stable until the handshake, then go to WAIT.
  - `busRequestValid` never drops before the handshake, even on flush.
- WAIT: on `busResponseValid` (or timeout, which is treated as an error):
  - Store: pulse `storeComplete` and `storeFault` (= error), go to IDLE.
  - Load not killed: register `loadData` (0 on error) and `loadFault`, set `loadDataValid`, go to HOLD.
  - Load killed: discard the response, go to IDLE.
- HOLD: `loadDataValid` stays high until `advance` or `flush` is sampled high, then clear it and go to IDLE.
- Kill flag:
  - Set by `flush` during REQUEST or WAIT of a load.
  - Cleared on entry to IDLE.
  - Stores are never killed; a committed store always completes.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle.
  - At `TIMEOUT_CYCLES` it forces an error response.
  - A real response in the same cycle wins: data taken from the bus, error flag from the bus.
- Responses in IDLE, REQUEST or HOLD are ignored.

## Timing
- Reset: state IDLE; every output 0 (`busByteEnable` 0); kill flag and counter 0. Reset mid-transaction abandons it with no outputs asserted.
- Load, ready immediate, response one cycle later:
  - cycle 0: `loadRequest`
  - cycle 1: `busRequestValid` and handshake
  - cycle 2: response
  - cycle 3: `loadDataValid`
  - Minimum latency is 3 cycles.
- Store: `storeComplete` is asserted in the cycle after the response. Memory clears `storeValid` on the same edge; the FSM is back in IDLE. Minimum 3 cycles from `storeValid`.
- A new request is accepted in the cycle after returning to IDLE. There is no back-to-back overlap.

## Structure
- Shared package `pack`:
  - `dataPortState_` enum (IDLE, REQUEST, WAIT, HOLD).
  - Byte-enable constant `BE_WORD = 4'b1111`.
- No sub-module. FSM, capture registers and watchdog live in one file.

## Test plan
- Load at 0x0000_1006, ready immediate, response `0xA1B2C3D4` two cycles later:
  - `busAddress` = 0x0000_1004
  - `loadDataValid` with `0xA1B2C3D4` held until `advance`
  - `loadFault` = 0
- Store with byte enables `4'b0100`, data `0x00EE0000`, ready held low 3 cycles:
  - request outputs stable throughout
  - exactly one `storeComplete` pulse after the response
- Flush in WAIT of a load:
  - response discarded, `loadDataValid` never set
  - next `loadRequest` accepted one cycle after the response
- `storeValid` and `loadRequest` both high in IDLE: store issued first (`busWrite` = 1).
- `TIMEOUT_CYCLES` = 4, no response: after 4 WAIT cycles, `loadDataValid` = 1, `loadFault` = 1, `loadData` = 0.
- Reset asserted in WAIT of a store:
  - next cycle all outputs 0
  - a late `busResponseValid` produces no `storeComplete`
